// File: rtl/regfile_write_scheduler_pkg.sv
// rtl/regfile_write_scheduler_pkg.sv - shared types and constants for the register-file write scheduler
package regfile_write_scheduler_pkg;

   localparam int REG_ID_W = 4;
   localparam int WORD_W   = 64;
   localparam int NREG     = 15;
   localparam logic [REG_ID_W-1:0] RNONE = 4'hF;

   // One queued register-file write.
   typedef struct packed {
      logic [REG_ID_W-1:0] dst;
      logic [WORD_W-1:0]   val;
   } pend_entry_t;

   // A request only counts when it is valid and names a real register.
   function automatic logic req_effective(input logic valid, input logic [REG_ID_W-1:0] dst);
      return valid && (dst != RNONE);
   endfunction

endpackage

// File: rtl/regfile_write_scheduler_fifo.sv
// rtl/regfile_write_scheduler_fifo.sv - pending-write FIFO with 2-wide push, 1-wide pop and age-ordered view
module regwr_fifo
   import regfile_write_scheduler_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push_a_valid,
   input  pend_entry_t                push_a,
   input  logic                       push_b_valid,
   input  pend_entry_t                push_b,
   input  logic                       pop,
   output pend_entry_t                head,
   output logic                       nonempty,
   output logic [$clog2(DEPTH):0]     count,
   output pend_entry_t                view_entry [DEPTH],
   output logic [DEPTH-1:0]           view_valid
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   pend_entry_t     mem_q [DEPTH];
   pend_entry_t     mem_d [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      n_push;
   logic            do_pop;

   // Next-state for storage, pointers and occupancy; push_b only lands behind push_a.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      n_push   = 2'd0;
      do_pop   = pop && (cnt_q != '0);
      if (push_a_valid) begin
         mem_d[wr_ptr_q] = push_a;
         n_push = 2'd1;
         if (push_b_valid) begin
            mem_d[wr_ptr_q + PW'(1)] = push_b;
            n_push = 2'd2;
         end
      end
      wr_ptr_d = wr_ptr_q + PW'(n_push);
      rd_ptr_d = rd_ptr_q + PW'(do_pop);
      cnt_d    = cnt_q + CW'(n_push) - CW'(do_pop);
   end

   // State register; storage contents need no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Present live entries oldest-first so the bypass search can let later slots win.
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         view_entry[k] = mem_q[rd_ptr_q + PW'(k)];
         view_valid[k] = (CW'(k) < cnt_q);
      end
   end

   assign head     = mem_q[rd_ptr_q];
   assign nonempty = (cnt_q != '0);
   assign count    = cnt_q;

endmodule

// File: rtl/regfile_write_scheduler.sv
// rtl/regfile_write_scheduler.sv - queues W-stage valE/valM writes onto one register-file write port
module regfile_write_scheduler
   import regfile_write_scheduler_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wr_valid_e,
   input  logic [REG_ID_W-1:0]     wr_dst_e,
   input  logic [WORD_W-1:0]       wr_val_e,
   input  logic                    wr_valid_m,
   input  logic [REG_ID_W-1:0]     wr_dst_m,
   input  logic [WORD_W-1:0]       wr_val_m,
   output logic                    stall,
   output logic                    rf_we,
   output logic [REG_ID_W-1:0]     rf_addr,
   output logic [WORD_W-1:0]       rf_data,
   input  logic [REG_ID_W-1:0]     rd_addr,
   output logic                    rd_hit,
   output logic [WORD_W-1:0]       rd_data,
   output logic [$clog2(DEPTH):0]  pending_cnt
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic                 eff_e, eff_m;
   logic                 push_a_valid, push_b_valid;
   pend_entry_t          push_a, push_b;
   pend_entry_t          head;
   logic                 fifo_nonempty;
   pend_entry_t          view_entry [DEPTH];
   logic [DEPTH-1:0]     view_valid;

   logic                 rf_we_q, rf_we_d;
   logic [REG_ID_W-1:0]  rf_addr_q, rf_addr_d;
   logic [WORD_W-1:0]    rf_data_q, rf_data_d;

   // Keep at least two free slots so a dual request can always be taken.
   assign stall = (pending_cnt > CW'(DEPTH - 2));

   // Filter requests and order them E then M; a shared destination keeps only valM.
   always_comb begin
      eff_e        = req_effective(wr_valid_e, wr_dst_e) && !stall;
      eff_m        = req_effective(wr_valid_m, wr_dst_m) && !stall;
      push_a_valid = 1'b0;
      push_b_valid = 1'b0;
      push_a       = '{dst: wr_dst_e, val: wr_val_e};
      push_b       = '{dst: wr_dst_m, val: wr_val_m};
      if (eff_e && eff_m && (wr_dst_e == wr_dst_m)) begin
         push_a_valid = 1'b1;
         push_a       = '{dst: wr_dst_m, val: wr_val_m};
      end else if (eff_e) begin
         push_a_valid = 1'b1;
         push_b_valid = eff_m;
      end else if (eff_m) begin
         push_a_valid = 1'b1;
         push_a       = '{dst: wr_dst_m, val: wr_val_m};
      end
   end

   regwr_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .push_a_valid (push_a_valid),
      .push_a       (push_a),
      .push_b_valid (push_b_valid),
      .push_b       (push_b),
      .pop          (fifo_nonempty),
      .head         (head),
      .nonempty     (fifo_nonempty),
      .count        (pending_cnt),
      .view_entry   (view_entry),
      .view_valid   (view_valid)
   );

   // Drain the head into the write-port register each cycle; address/data hold when idle.
   always_comb begin
      rf_we_d   = fifo_nonempty;
      rf_addr_d = rf_addr_q;
      rf_data_d = rf_data_q;
      if (fifo_nonempty) begin
         rf_addr_d = head.dst;
         rf_data_d = head.val;
      end
   end

   // Write-port register; reset parks the address on RNONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         rf_we_q   <= 1'b0;
         rf_addr_q <= RNONE;
         rf_data_q <= '0;
      end else begin
         rf_we_q   <= rf_we_d;
         rf_addr_q <= rf_addr_d;
         rf_data_q <= rf_data_d;
      end
   end

   // Bypass search: the in-flight rf_* write is oldest, then FIFO oldest to youngest, last match wins.
   always_comb begin
      rd_hit  = 1'b0;
      rd_data = '0;
      if (rd_addr != RNONE) begin
         if (rf_we_q && (rf_addr_q == rd_addr)) begin
            rd_hit  = 1'b1;
            rd_data = rf_data_q;
         end
         for (int k = 0; k < DEPTH; k++) begin
            if (view_valid[k] && (view_entry[k].dst == rd_addr)) begin
               rd_hit  = 1'b1;
               rd_data = view_entry[k].val;
            end
         end
      end
   end

   assign rf_we   = rf_we_q;
   assign rf_addr = rf_addr_q;
   assign rf_data = rf_data_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb/tb_regfile_write_scheduler.sv - self-checking bench for regfile_write_scheduler
module tb_regfile_write_scheduler;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_valid_e, wr_valid_m;
   logic [3:0]  wr_dst_e, wr_dst_m;
   logic [63:0] wr_val_e, wr_val_m;
   logic        stall;
   logic        rf_we;
   logic [3:0]  rf_addr;
   logic [63:0] rf_data;
   logic [3:0]  rd_addr;
   logic        rd_hit;
   logic [63:0] rd_data;
   logic [2:0]  pending_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        ve;
      logic [3:0]  de;
      logic [63:0] xe;
      logic        vm;
      logic [3:0]  dm;
      logic [63:0] xm;
      logic [3:0]  ra;
      logic [2:0]  cnt;
      logic        stl;
      logic        we;
      logic        hit;
      logic [63:0] rdat;
   } vec_t;

   typedef struct {
      logic [3:0]  dst;
      logic [63:0] val;
   } wr_t;

   vec_t vecs [18];
   wr_t  exp_q [$];

   regfile_write_scheduler #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .wr_valid_e  (wr_valid_e),
      .wr_dst_e    (wr_dst_e),
      .wr_val_e    (wr_val_e),
      .wr_valid_m  (wr_valid_m),
      .wr_dst_m    (wr_dst_m),
      .wr_val_m    (wr_val_m),
      .stall       (stall),
      .rf_we       (rf_we),
      .rf_addr     (rf_addr),
      .rf_data     (rf_data),
      .rd_addr     (rd_addr),
      .rd_hit      (rd_hit),
      .rd_data     (rd_data),
      .pending_cnt (pending_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: at the falling edge, compare any write on rf_* against the oldest
   // expected entry, then record what the model says the coming edge will accept.
   always @(negedge clk) begin
      wr_t w;
      if (rf_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_write", 64'(rf_addr), 64'hF);
         end else begin
            w = exp_q.pop_front();
            chk("sb_rf_addr", 64'(rf_addr), 64'(w.dst));
            chk("sb_rf_data", rf_data, w.val);
         end
      end
      if (reset) begin
         exp_q.delete();
      end else if (!stall) begin
         if (wr_valid_e && wr_dst_e != 4'hF && wr_valid_m && wr_dst_m != 4'hF && wr_dst_e == wr_dst_m) begin
            exp_q.push_back('{dst: wr_dst_m, val: wr_val_m});
         end else begin
            if (wr_valid_e && wr_dst_e != 4'hF) exp_q.push_back('{dst: wr_dst_e, val: wr_val_e});
            if (wr_valid_m && wr_dst_m != 4'hF) exp_q.push_back('{dst: wr_dst_m, val: wr_val_m});
         end
      end
   end

   task automatic drive(input logic ve, input logic [3:0] de, input logic [63:0] xe,
                        input logic vm, input logic [3:0] dm, input logic [63:0] xm);
      wr_valid_e = ve; wr_dst_e = de; wr_val_e = xe;
      wr_valid_m = vm; wr_dst_m = dm; wr_val_m = xm;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_cnt [6];

      //           ve  de    xe      vm  dm    xm      ra    cnt  stl we  hit rdat
      vecs[0]  = '{1, 4'd3, 64'h11, 0, 4'd0, 64'h0,  4'd3, 3'd1, 0, 0, 1, 64'h11};
      vecs[1]  = '{0, 4'd0, 64'h0,  0, 4'd0, 64'h0,  4'd3, 3'd0, 0, 1, 1, 64'h11};
      vecs[2]  = '{0, 4'd0, 64'h0,  0, 4'd0, 64'h0,  4'd3, 3'd0, 0, 0, 0, 64'h0};
      vecs[3]  = '{1, 4'd4, 64'hA0, 1, 4'd4, 64'hB0, 4'd4, 3'd1, 0, 0, 1, 64'hB0};
      vecs[4]  = '{0, 4'd0, 64'h0,  0, 4'd0, 64'h0,  4'd4, 3'd0, 0, 1, 1, 64'hB0};
      vecs[5]  = '{1, 4'd4, 64'h8,  1, 4'd0, 64'h55, 4'd0, 3'd2, 0, 0, 1, 64'h55};
      vecs[6]  = '{0, 4'd0, 64'h0,  0, 4'd0, 64'h0,  4'd4, 3'd1, 0, 1, 1, 64'h8};
      vecs[7]  = '{0, 4'd0, 64'h0,  0, 4'd0, 64'h0,  4'd0, 3'd0, 0, 1, 1, 64'h55};
      vecs[8]  = '{0, 4'd0, 64'h0,  0, 4'd0, 64'h0,  4'd0, 3'd0, 0, 0, 0, 64'h0};
      vecs[9]  = '{1, 4'd2, 64'h1,  0, 4'd0, 64'h0,  4'd2, 3'd1, 0, 0, 1, 64'h1};
      vecs[10] = '{1, 4'd2, 64'h2,  0, 4'd0, 64'h0,  4'd2, 3'd1, 0, 1, 1, 64'h2};
      vecs[11] = '{1, 4'hF, 64'h77, 1, 4'hF, 64'h99, 4'hF, 3'd0, 0, 1, 0, 64'h0};
      vecs[12] = '{0, 4'd0, 64'h0,  0, 4'd0, 64'h0,  4'd2, 3'd0, 0, 0, 0, 64'h0};
      vecs[13] = '{0, 4'd5, 64'h33, 0, 4'd6, 64'h44, 4'd5, 3'd0, 0, 0, 0, 64'h0};
      vecs[14] = '{1, 4'd5, 64'hAA, 0, 4'd5, 64'h0,  4'd5, 3'd1, 0, 0, 1, 64'hAA};
      vecs[15] = '{0, 4'd0, 64'h0,  1, 4'd6, 64'hBB, 4'd5, 3'd1, 0, 1, 1, 64'hAA};
      vecs[16] = '{0, 4'd0, 64'h0,  0, 4'd0, 64'h0,  4'd6, 3'd0, 0, 1, 1, 64'hBB};
      vecs[17] = '{0, 4'd0, 64'h0,  0, 4'd0, 64'h0,  4'd6, 3'd0, 0, 0, 0, 64'h0};

      // Reset with requests present: they must be ignored.
      reset = 1'b1;
      rd_addr = 4'd1;
      drive(1, 4'd1, 64'hDEAD, 1, 4'd2, 64'hBEEF);
      step();
      step();
      chk("rst_cnt",     64'(pending_cnt), 64'd0);
      chk("rst_rf_we",   64'(rf_we),       64'd0);
      chk("rst_rf_addr", 64'(rf_addr),     64'hF);
      chk("rst_rf_data", rf_data,          64'd0);
      chk("rst_stall",   64'(stall),       64'd0);
      chk("rst_rd_hit",  64'(rd_hit),      64'd0);
      reset = 1'b0;
      drive(0, 4'd0, 64'h0, 0, 4'd0, 64'h0);
      step();
      chk("post_rst_rf_we", 64'(rf_we), 64'd0);

      // Table-driven single-cycle vectors.
      for (int i = 0; i < 18; i++) begin
         drive(vecs[i].ve, vecs[i].de, vecs[i].xe, vecs[i].vm, vecs[i].dm, vecs[i].xm);
         rd_addr = vecs[i].ra;
         step();
         chk($sformatf("v%0d_cnt", i),   64'(pending_cnt), 64'(vecs[i].cnt));
         chk($sformatf("v%0d_stall", i), 64'(stall),       64'(vecs[i].stl));
         chk($sformatf("v%0d_rf_we", i), 64'(rf_we),       64'(vecs[i].we));
         chk($sformatf("v%0d_hit", i),   64'(rd_hit),      64'(vecs[i].hit));
         chk($sformatf("v%0d_rdata", i), rd_data,          vecs[i].rdat);
      end
      drive(0, 4'd0, 64'h0, 0, 4'd0, 64'h0);
      step();

      // Back-pressure: dual requests every cycle, occupancy alternates 2/3 once filled.
      exp_cnt = '{2, 3, 2, 3, 2, 3};
      for (int i = 0; i < 6; i++) begin
         drive(1, 4'd1, 64'h100 + 64'(i), 1, 4'd2, 64'h200 + 64'(i));
         step();
         chk($sformatf("bp%0d_cnt", i),   64'(pending_cnt), 64'(exp_cnt[i]));
         chk($sformatf("bp%0d_stall", i), 64'(stall),       64'(exp_cnt[i] == 3));
      end
      drive(0, 4'd0, 64'h0, 0, 4'd0, 64'h0);
      for (int i = 0; i < 4; i++) step();
      chk("bp_drained_cnt", 64'(pending_cnt), 64'd0);
      chk("bp_sb_empty",    64'(exp_q.size()), 64'd0);

      // Reset with three writes pending.
      drive(1, 4'd7, 64'h70, 1, 4'd8, 64'h80);
      step();
      drive(1, 4'd9, 64'h90, 1, 4'd10, 64'hA0);
      step();
      chk("rp_cnt_before", 64'(pending_cnt), 64'd3);
      reset = 1'b1;
      rd_addr = 4'd9;
      step();
      chk("rp_cnt",     64'(pending_cnt), 64'd0);
      chk("rp_rf_we",   64'(rf_we),       64'd0);
      chk("rp_rf_addr", 64'(rf_addr),     64'hF);
      chk("rp_rd_hit",  64'(rd_hit),      64'd0);
      reset = 1'b0;
      drive(0, 4'd0, 64'h0, 0, 4'd0, 64'h0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("rp_stale%0d_rf_we", i), 64'(rf_we), 64'd0);
      end
      chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_write_scheduler.md
REGFILE_WRITE_SCHEDULER -- requirements
Module: regfile_write_scheduler

Interface
REQ-001 Parameter: DEPTH, 4, FIFO entries for pending writes; power of 2, minimum 2.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: wr_valid_e  in  1  W stage requests a valE write.
REQ-005 Port: wr_dst_e  in  4  valE destination register ID; 4'hF = RNONE.
REQ-006 Port: wr_val_e  in  64  valE data.
REQ-007 Port: wr_valid_m / wr_dst_m / wr_val_m  in  1/4/64  valM request, destination ID, data.
REQ-008 Port: stall  out  1  W stage must hold; inputs ignored this cycle.
REQ-009 Port: rf_we / rf_addr / rf_data  out  1/4/64  registered single write port to the 15-entry register file.
REQ-010 Port: rd_addr  in  4  decode-stage read ID for pending-write bypass.
REQ-011 Port: rd_hit / rd_data  out  1/64  combinational bypass: a pending write to rd_addr exists, and its value.
REQ-012 Port: pending_cnt  out  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-013 Request is effective only when its valid is 1 and its dst != 4'hF; otherwise discarded.
REQ-014 stall SHALL be 1, combinationally, when pending_cnt > DEPTH-2; while stall=1 no request is accepted.
REQ-015 Both effective, dst_e == dst_m: only M enqueued (valM wins, popq %rsp rule).
REQ-016 Both effective, different dst: E enqueued first, then M, same edge (two slots).
REQ-017 Each edge with FIFO non-empty: head popped; rf_we<=1, rf_addr<=head dst, rf_data<=head val; else rf_we<=0, rf_addr/rf_data hold.
REQ-018 Enqueue and dequeue in the same edge: occupancy = old + enqueued - 1; empty FIFO is never bypassed by the enqueue path.
REQ-019 Latency: a lone write accepted at edge N appears on rf_* after edge N+1; drain rate one write per cycle.
REQ-020 Pointers wrap modulo DEPTH; occupancy never exceeds DEPTH; overflow and underflow are impossible by REQ-014/REQ-017.
REQ-021 Bypass search covers all FIFO entries plus the rf_* register while rf_we=1; youngest match wins (FIFO tail side first, rf_* register last).
REQ-022 rd_addr == 4'hF or no match: rd_hit=0, rd_data=0.
REQ-023 Write order to the register file SHALL equal acceptance order, E before M within a cycle.

Reset
REQ-024 On reset: FIFO pointers and pending_cnt = 0, rf_we=0, rf_addr=4'hF, rf_data=0, rd_hit=0, stall=0.
REQ-025 Reset mid-operation discards all pending writes; no rf_we pulse in the cycle after reset.
REQ-026 Requests presented while reset=1 are ignored.

Structure
REQ-027 Shared package: RNONE=4'hF, NREG=15, WORD_W=64, REG_ID_W=4, and the pending-write entry type (dst, val).
REQ-028 One sub-module: regwr_fifo (DEPTH entries, 2-wide push, 1-wide pop, entry visibility for bypass search).
REQ-029 Bypass priority search, request filtering and rf_* output register stay in regfile_write_scheduler.

Verification
REQ-030 Single: E dst=3 val=0x11 at edge 1 -> rf_we=1, rf_addr=3, rf_data=0x11 after edge 2; rf_we=0 after edge 3.
REQ-031 Pop same dst: E dst=4 val=0xA0, M dst=4 val=0xB0 -> exactly one write, rf_addr=4, rf_data=0xB0.
REQ-032 Dual: E dst=4 val=0x8, M dst=0 val=0x55 -> writes (4,0x8) then (0,0x55) on consecutive cycles; pending_cnt 2 then 1 then 0.
REQ-033 Back-pressure, DEPTH=4: dual requests every cycle -> stall=1 once pending_cnt=3; no request lost or duplicated; rf order matches acceptance.
REQ-034 Bypass: writes (2,0x1) then (2,0x2) queued, rd_addr=2 -> rd_hit=1, rd_data=0x2; rd_addr=0xF -> rd_hit=0; dst=0xF request -> no enqueue.
REQ-035 Reset with 3 pending -> pending_cnt=0, rf_we=0, rf_addr=0xF next cycle; no stale write appears afterwards.
